// File: rtl/logic_issue_queue.sv
// logic_issue_queue: request FIFO and issue FSM feeding the andornot logic unit
module logic_issue_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [1:0]               in_ctrl,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [1:0]               alu_ctrl,
    input  logic [WIDTH-1:0]         alu_s,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_s,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, EVAL, RESULT} state_t;
    state_t state, next;
    logic [2*WIDTH+1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push, pop;
    logic [WIDTH-1:0] res;
    assign in_ready = !rst && (level != (AW+1)'(DEPTH));
    assign push = in_valid && in_ready;
    assign res = (alu_ctrl == 2'b11) ? '0 : alu_s;
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : next;
    // pop the head whenever the unit is free and the FIFO holds a request
    always_comb begin
        pop = (level != '0) && (state == IDLE || (state == RESULT && out_ready));
        next = pop ? EVAL : (state == EVAL) ? RESULT : (state == RESULT && out_ready) ? IDLE : state;
    end
    // FIFO storage, not reset: occupancy is tracked by level and pointers
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {in_ctrl, in_a, in_b};
    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // operand registers load on pop; result captured in EVAL and held until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            {alu_ctrl, alu_a, alu_b} <= '0;
            out_valid   <= 1'b0;
            out_s       <= '0;
            out_zero    <= 1'b0;
            out_neg     <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            if (pop) {alu_ctrl, alu_a, alu_b} <= mem[rd_ptr];
            if (state == EVAL) begin
                out_s       <= res;
                out_zero    <= (res == '0);
                out_neg     <= res[WIDTH-1];
                out_illegal <= (alu_ctrl == 2'b11);
                out_valid   <= 1'b1;
            end else if (state == RESULT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_logic_issue_queue.sv
// tb_logic_issue_queue: scoreboard bench with an andornot model on the alu port
module tb_logic_issue_queue;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, out_zero, out_neg, out_illegal;
    logic [7:0] in_a, in_b, alu_a, alu_b, alu_s, out_s;
    logic [1:0] in_ctrl, alu_ctrl;
    logic [2:0] level;
    int n_cmp = 0, n_err = 0, cyc = 0;
    logic [10:0] exp_q [$];
    int hs_cyc [$];
    logic [10:0] cur_exp;

    logic_issue_queue #(.DEPTH(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_s(alu_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
        .out_zero(out_zero), .out_neg(out_neg), .out_illegal(out_illegal), .level(level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign alu_s = (alu_ctrl == 2'b00) ? (alu_a & alu_b) :
                   (alu_ctrl == 2'b01) ? (alu_a | alu_b) :
                   (alu_ctrl == 2'b10) ? ~alu_a : 8'hA5;

    function automatic logic [10:0] mk(input logic [7:0] s, input logic ill);
        return {s, s == 8'h00, s[7], ill};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (in_valid && in_ready) exp_q.push_back(cur_exp);
        if (out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got %0h with nothing outstanding", {out_s, out_zero, out_neg, out_illegal});
            end else begin
                check("result", {out_s, out_zero, out_neg, out_illegal}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c, input logic [7:0] es);
        in_a = a;
        in_b = b;
        in_ctrl = c;
        cur_exp = mk(es, c == 2'b11);
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c, input logic [7:0] es);
        drive(a, b, c, es);
        wait_accept();
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain_outstanding", exp_q.size(), 0);
        check("drain_out_valid", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int idx, stale;
        rst = 1'b1;
        out_ready = 1'b1;
        drive(8'h11, 8'h22, 2'b01, 8'h33);
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_level", level, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_alu", {alu_ctrl, alu_a, alu_b}, 0);
        check("rst_out", {out_s, out_zero, out_neg, out_illegal}, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);

        send(8'h05, 8'h04, 2'b00, 8'h04);
        check("and_level", level, 1);
        check("and_out_valid_k", out_valid, 0);
        tick();
        check("and_alu", {alu_ctrl, alu_a, alu_b}, {2'b00, 8'h05, 8'h04});
        check("and_out_valid_k1", out_valid, 0);
        tick();
        check("and_out_valid_k2", out_valid, 1);
        check("and_out_s", out_s, 8'h04);
        drain();

        idx = hs_cyc.size();
        send(8'h05, 8'h00, 2'b10, 8'hFA);
        send(8'h05, 8'hFA, 2'b01, 8'hFF);
        drain();
        check("b2b_count", hs_cyc.size() - idx, 2);
        if (hs_cyc.size() - idx == 2) check("b2b_spacing", hs_cyc[idx+1] - hs_cyc[idx], 2);

        out_ready = 1'b0;
        send(8'hF0, 8'h0F, 2'b00, 8'h00);
        send(8'hF0, 8'h0F, 2'b01, 8'hFF);
        send(8'h3C, 8'h00, 2'b10, 8'hC3);
        send(8'h81, 8'h80, 2'b00, 8'h80);
        send(8'h12, 8'h34, 2'b01, 8'h36);
        drive(8'h00, 8'h00, 2'b10, 8'hFF);
        tick();
        tick();
        check("full_level", level, 4);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_head_out_s", out_s, 8'h00);
        out_ready = 1'b1;
        wait_accept();
        drain();
        check("full_level_drained", level, 0);

        send(8'h05, 8'h01, 2'b11, 8'h00);
        tick();
        tick();
        check("illegal_flags", {out_s, out_zero, out_neg, out_illegal}, {8'h00, 3'b101});
        drain();

        out_ready = 1'b0;
        send(8'h01, 8'h02, 2'b01, 8'h03);
        send(8'hF0, 8'hF0, 2'b00, 8'hF0);
        send(8'hAA, 8'h00, 2'b10, 8'h55);
        send(8'h0F, 8'hF0, 2'b01, 8'hFF);
        check("midrst_level_before", level, 3);
        check("midrst_out_valid_before", out_valid, 1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("midrst_level", level, 0);
        check("midrst_out_valid", out_valid, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) stale++;
        end
        check("midrst_stale", stale, 0);
        send(8'hC0, 8'h0C, 2'b01, 8'hCC);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
